// File: rtl/turn_signal_if.sv
// Request/lamp bundle between the switch debouncers and the tail-light sequencer.
// The master drives the level requests; the slave (sequencer) drives the lamps and busy.
interface turn_signal_if #(
  parameter int LIGHTS = 3
);
  logic              left;
  logic              right;
  logic              hazard;
  logic              brake;
  logic [LIGHTS-1:0] lights_l;
  logic [LIGHTS-1:0] lights_r;
  logic              busy;

  modport master (
    output left, right, hazard, brake,
    input  lights_l, lights_r, busy
  );

  modport slave (
    input  left, right, hazard, brake,
    output lights_l, lights_r, busy
  );
endinterface

// File: rtl/turn_signal_seq.sv
// Tail-light sequencer: thermometer sweep of LIGHTS lamps per side for left, right and hazard,
// one frame per DIV cycles, with a brake overlay on every side that is not sweeping.
module turn_signal_seq #(
  parameter int LIGHTS = 3,
  parameter int DIV    = 1
) (
  input  logic         clk,
  input  logic         reset,
  turn_signal_if.slave bus
);
  localparam int SW = $clog2(LIGHTS + 1);
  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic [1:0] {IDLE, RUN_L, RUN_R, RUN_H} state_e;

  state_e            state_q, state_d;
  logic [SW-1:0]     step_q, step_d;
  logic [PW-1:0]     pre_q, pre_d;
  logic [LIGHTS-1:0] lights_l_q, lights_l_d;
  logic [LIGHTS-1:0] lights_r_q, lights_r_d;
  logic              busy_q, busy_d;
  logic              tick;
  logic [LIGHTS-1:0] pattern;

  assign tick = (pre_q == PW'(DIV - 1));

  always_comb begin
    // NOTE: every variable gets its hold/default value first, so no path can infer a latch.
    state_d    = state_q;
    step_d     = step_q;
    pre_d      = pre_q;
    pattern    = '0;
    lights_l_d = '0;
    lights_r_d = '0;

    case (state_q)
      IDLE: begin
        if (bus.hazard || (bus.left && bus.right)) state_d = RUN_H;
        else if (bus.left)                         state_d = RUN_L;
        else if (bus.right)                        state_d = RUN_R;
        if (state_d != IDLE) begin
          step_d = SW'(1);
          pre_d  = '0;
        end
      end
      default: begin
        if (tick) begin
          pre_d = '0;
          // Step 0 is the off gap frame; its tick ends the sequence.
          if (step_q == '0)                 state_d = IDLE;
          else if (step_q == SW'(LIGHTS))   step_d  = '0;
          else                              step_d  = step_q + SW'(1);
        end else begin
          pre_d = pre_q + PW'(1);
        end
      end
    endcase

    for (int i = 0; i < LIGHTS; i++) pattern[i] = (int'(step_d) > i);

    // Lamps follow the next state so the new frame shows right after its edge.
    case (state_d)
      RUN_L: begin
        lights_l_d = pattern;
        lights_r_d = bus.brake ? '1 : '0;
      end
      RUN_R: begin
        lights_l_d = bus.brake ? '1 : '0;
        lights_r_d = pattern;
      end
      RUN_H: begin
        lights_l_d = pattern;
        lights_r_d = pattern;
      end
      default: begin
        lights_l_d = bus.brake ? '1 : '0;
        lights_r_d = bus.brake ? '1 : '0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      step_q     <= '0;
      pre_q      <= '0;
      lights_l_q <= '0;
      lights_r_q <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      pre_q      <= pre_d;
      lights_l_q <= lights_l_d;
      lights_r_q <= lights_r_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.lights_l = lights_l_q;
  assign bus.lights_r = lights_r_q;
  assign bus.busy     = busy_q;
endmodule
